demo_scene_sequencer: RTL and testbench

Frame-rate scheduler that shares the demo kit's video pipeline between its effect generators. It picks the active scene and drives a per-frame fade level to the colour stage. It also tells the active effect how many frames it has been running. Frame-synchronous: all progress is driven by the frame tick from the VGA timing generator. A one-cycle skip request from the user input advances to the next scene early.

---
 rtl/demo_scene_sequencer.sv | 109 ++++++++++
 tb/tb_demo_scene_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: frame-synchronous scene scheduler for the demo kit.
// Rotates through NUM_SCENES effects, fading each one in, holding it at full
// brightness for SCENE_FRAMES frames, then fading it out before moving on.
// A skip pulse cuts the current scene short by jumping straight to fade-out.
module demo_scene_sequencer #(
    parameter int NUM_SCENES   = 4,   // 2..8
    parameter int SCENE_FRAMES = 240  // 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic       skip,
    output logic [2:0] scene,
    output logic [3:0] brightness,
    output logic [7:0] frame_count,
    output logic [1:0] phase,
    output logic       scene_start
);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        HOLD     = 2'd1,
        FADE_OUT = 2'd2,
        SWITCH   = 2'd3
    } phase_t;

    localparam logic [2:0] LAST_SCENE = 3'(NUM_SCENES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(SCENE_FRAMES - 1);

    phase_t     state;
    logic [7:0] hold_cnt;
    logic       tick_ok;

    // A frame tick only counts when not paused and not in the one-cycle switch.
    assign tick_ok = frame_tick && !pause && (state != SWITCH);

    // The phase output is the state register itself, so it stays registered.
    assign phase = state;

    // Scene sequencing: phase transitions, fade level, counters and start pulse.
    // NOTE: non-blocking assignments throughout, so every output is a plain
    // register sampled at the edge and the branch order below cannot race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FADE_IN;
            scene       <= 3'd0;
            brightness  <= 4'd0;
            frame_count <= 8'd0;
            hold_cnt    <= 8'd0;
            scene_start <= 1'b0;
        end else begin
            scene_start <= 1'b0;

            // Frames spent in the current scene; saturates rather than wraps.
            if (tick_ok && frame_count != 8'hFF) begin
                frame_count <= frame_count + 8'd1;
            end

            case (state)
                FADE_IN: begin
                    // Skip takes priority and freezes the fade level for this cycle.
                    if (skip) begin
                        state <= FADE_OUT;
                    end else if (tick_ok && brightness != 4'hF) begin
                        brightness <= brightness + 4'd1;
                        if (brightness == 4'hE) begin
                            state    <= HOLD;
                            hold_cnt <= 8'd0;
                        end
                    end
                end

                HOLD: begin
                    if (tick_ok) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                    if (skip || (tick_ok && hold_cnt == HOLD_LAST)) begin
                        state <= FADE_OUT;
                    end
                end

                FADE_OUT: begin
                    // Skip is deliberately ignored here; the scene is already ending.
                    // A fade-out entered at level 0 (skip before any tick) still
                    // finishes on the next accepted tick instead of stalling.
                    if (tick_ok) begin
                        if (brightness != 4'h0) begin
                            brightness <= brightness - 4'd1;
                        end
                        if (brightness <= 4'h1) begin
                            state <= SWITCH;
                        end
                    end
                end

                SWITCH: begin
                    scene       <= (scene == LAST_SCENE) ? 3'd0 : scene + 3'd1;
                    frame_count <= 8'd0;
                    scene_start <= 1'b1;
                    state       <= FADE_IN;
                end

                default: state <= FADE_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb_demo_scene_sequencer: directed scoreboard bench for demo_scene_sequencer.
// dut_a runs with NUM_SCENES=3, SCENE_FRAMES=4; dut_b with SCENE_FRAMES=255
// covers frame_count saturation.
module tb_demo_scene_sequencer;

    typedef struct packed {
        logic [2:0] scene;
        logic [3:0] brightness;
        logic [7:0] frame_count;
        logic [1:0] phase;
        logic       scene_start;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic pause = 1'b0;
    logic skip = 1'b0;
    logic frame_tick_b = 1'b0;
    logic pause_b = 1'b0;
    logic skip_b = 1'b0;

    logic [2:0] scene_a, scene_b;
    logic [3:0] bright_a, bright_b;
    logic [7:0] fc_a, fc_b;
    logic [1:0] phase_a, phase_b;
    logic       ss_a, ss_b;

    out_t obs_a, obs_b;
    assign obs_a = {scene_a, bright_a, fc_a, phase_a, ss_a};
    assign obs_b = {scene_b, bright_b, fc_b, phase_b, ss_b};

    int   errors = 0;
    int   checks = 0;
    int   ss_count = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    demo_scene_sequencer #(.NUM_SCENES(3), .SCENE_FRAMES(4)) dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .skip(skip),
        .scene(scene_a), .brightness(bright_a), .frame_count(fc_a),
        .phase(phase_a), .scene_start(ss_a)
    );

    demo_scene_sequencer #(.NUM_SCENES(3), .SCENE_FRAMES(255)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick_b), .pause(pause_b), .skip(skip_b),
        .scene(scene_b), .brightness(bright_b), .frame_count(fc_b),
        .phase(phase_b), .scene_start(ss_b)
    );

    // Count scene_start pulses on dut_a, sampled mid-cycle.
    always @(negedge clk) begin
        if (ss_a) ss_count++;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input logic [2:0] sc, input logic [3:0] br, input logic [7:0] fc,
                              input logic [1:0] ph, input logic ss);
        out_t e;
        e = {sc, br, fc, ph, ss};
        exp_q.push_back(e);
    endtask

    task automatic compare(input string tag, input out_t obs);
        out_t e;
        check({tag, ".queued"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, ".scene"},       32'(obs.scene),       32'(e.scene));
        check({tag, ".brightness"},  32'(obs.brightness),  32'(e.brightness));
        check({tag, ".frame_count"}, 32'(obs.frame_count), 32'(e.frame_count));
        check({tag, ".phase"},       32'(obs.phase),       32'(e.phase));
        check({tag, ".scene_start"}, 32'(obs.scene_start), 32'(e.scene_start));
    endtask

    // One clock of stimulus on dut_a; outputs are stable 1 time unit after the edge.
    task automatic step(input logic t, input logic p, input logic s);
        @(negedge clk);
        frame_tick = t;
        pause      = p;
        skip       = s;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        skip       = 1'b0;
    endtask

    task automatic step_b(input logic t);
        @(negedge clk);
        frame_tick_b = t;
        @(posedge clk);
        #1;
        frame_tick_b = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // A full undisturbed scene, with a stray tick during SWITCH that must be ignored.
    task automatic full_scene(input string tag, input logic [2:0] cur, input logic [2:0] nxt);
        ticks(34);
        expect_out(cur, 4'd0, 8'd34, 2'd3, 1'b0);
        compare({tag, ".switch"}, obs_a);
        step(1'b1, 1'b0, 1'b0);
        expect_out(nxt, 4'd0, 8'd0, 2'd0, 1'b1);
        compare({tag, ".enter"}, obs_a);
        step(1'b0, 1'b0, 1'b0);
        expect_out(nxt, 4'd0, 8'd0, 2'd0, 1'b0);
        compare({tag, ".settle"}, obs_a);
    endtask

    initial begin
        // Reset state on both instances.
        repeat (2) @(posedge clk);
        #1;
        expect_out(3'd0, 4'd0, 8'd0, 2'd0, 1'b0);
        compare("reset_a", obs_a);
        expect_out(3'd0, 4'd0, 8'd0, 2'd0, 1'b0);
        compare("reset_b", obs_b);
        @(negedge clk);
        rst = 1'b0;

        // Normal run through scene 0.
        step(1'b1, 1'b0, 1'b0);
        expect_out(3'd0, 4'd1, 8'd1, 2'd0, 1'b0);
        compare("norm.first_tick", obs_a);
        ticks(14);
        expect_out(3'd0, 4'd15, 8'd15, 2'd1, 1'b0);
        compare("norm.hold", obs_a);
        ticks(3);
        expect_out(3'd0, 4'd15, 8'd18, 2'd1, 1'b0);
        compare("norm.hold_last", obs_a);
        ticks(1);
        expect_out(3'd0, 4'd15, 8'd19, 2'd2, 1'b0);
        compare("norm.fade_out", obs_a);
        ticks(14);
        expect_out(3'd0, 4'd1, 8'd33, 2'd2, 1'b0);
        compare("norm.fade_1", obs_a);
        ticks(1);
        expect_out(3'd0, 4'd0, 8'd34, 2'd3, 1'b0);
        compare("norm.switch", obs_a);
        step(1'b0, 1'b0, 1'b0);
        expect_out(3'd1, 4'd0, 8'd0, 2'd0, 1'b1);
        compare("norm.enter", obs_a);
        step(1'b0, 1'b0, 1'b0);
        expect_out(3'd1, 4'd0, 8'd0, 2'd0, 1'b0);
        compare("norm.pulse_end", obs_a);

        // Wrap: scenes 1 -> 2 -> 0.
        full_scene("wrap1", 3'd1, 3'd2);
        full_scene("wrap2", 3'd2, 3'd0);
        check("wrap.pulse_count", 32'(ss_count), 32'd3);

        // Skip coincident with a tick in FADE_IN.
        ticks(7);
        expect_out(3'd0, 4'd7, 8'd7, 2'd0, 1'b0);
        compare("skip.pre", obs_a);
        step(1'b1, 1'b0, 1'b1);
        expect_out(3'd0, 4'd7, 8'd8, 2'd2, 1'b0);
        compare("skip.fade_in", obs_a);
        ticks(7);
        expect_out(3'd0, 4'd0, 8'd15, 2'd3, 1'b0);
        compare("skip.switch", obs_a);
        step(1'b0, 1'b0, 1'b0);
        expect_out(3'd1, 4'd0, 8'd0, 2'd0, 1'b1);
        compare("skip.enter", obs_a);

        // Pause in HOLD, then skip while paused.
        ticks(15);
        expect_out(3'd1, 4'd15, 8'd15, 2'd1, 1'b0);
        compare("pause.hold", obs_a);
        ticks(1);
        expect_out(3'd1, 4'd15, 8'd16, 2'd1, 1'b0);
        compare("pause.pre", obs_a);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        expect_out(3'd1, 4'd15, 8'd16, 2'd1, 1'b0);
        compare("pause.frozen", obs_a);
        step(1'b0, 1'b1, 1'b1);
        expect_out(3'd1, 4'd15, 8'd16, 2'd2, 1'b0);
        compare("pause.skip", obs_a);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        expect_out(3'd1, 4'd15, 8'd16, 2'd2, 1'b0);
        compare("pause.stall", obs_a);
        ticks(15);
        expect_out(3'd1, 4'd0, 8'd31, 2'd3, 1'b0);
        compare("pause.switch", obs_a);
        step(1'b0, 1'b0, 1'b0);
        expect_out(3'd2, 4'd0, 8'd0, 2'd0, 1'b1);
        compare("pause.enter", obs_a);

        // Skip in FADE_OUT is ignored; async reset mid-fade in scene 2.
        ticks(19);
        step(1'b1, 1'b0, 1'b1);
        expect_out(3'd2, 4'd14, 8'd20, 2'd2, 1'b0);
        compare("rst.skip_ignored", obs_a);
        ticks(5);
        expect_out(3'd2, 4'd9, 8'd25, 2'd2, 1'b0);
        compare("rst.pre", obs_a);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_out(3'd0, 4'd0, 8'd0, 2'd0, 1'b0);
        compare("rst.async", obs_a);
        @(posedge clk);
        #1;
        expect_out(3'd0, 4'd0, 8'd0, 2'd0, 1'b0);
        compare("rst.held", obs_a);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        expect_out(3'd0, 4'd1, 8'd1, 2'd0, 1'b0);
        compare("rst.restart", obs_a);

        // Skip coincident with a tick in HOLD: skip wins, frame_count advances.
        ticks(14);
        step(1'b1, 1'b0, 1'b1);
        expect_out(3'd0, 4'd15, 8'd16, 2'd2, 1'b0);
        compare("hold_skip", obs_a);

        // Saturation on dut_b (SCENE_FRAMES=255).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 255; i++) step_b(1'b1);
        expect_out(3'd0, 4'd15, 8'd255, 2'd1, 1'b0);
        compare("sat.255", obs_b);
        for (int i = 0; i < 14; i++) step_b(1'b1);
        expect_out(3'd0, 4'd15, 8'd255, 2'd1, 1'b0);
        compare("sat.269", obs_b);
        step_b(1'b1);
        expect_out(3'd0, 4'd15, 8'd255, 2'd2, 1'b0);
        compare("sat.270", obs_b);
        step_b(1'b1);
        expect_out(3'd0, 4'd14, 8'd255, 2'd2, 1'b0);
        compare("sat.271", obs_b);

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
